// File: rtl/chart_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : chart_pkg
// Brief    : Shared chart types, scheduler state encoding and default sizes.
// Revision : 1.0 - initial release
// ============================================================================
package chart_pkg;

    // Defaults shared with the lane engine and the VGA overlay
    localparam int c_time_w = 16;
    localparam int c_addr_w = 10;
    localparam int c_lanes  = 4;
    localparam int c_lead   = 60;

    typedef struct packed {
        logic [c_time_w-1:0] hit_time;
        logic [c_lanes-1:0]  lane_mask;
    } chart_entry_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_ISSUE = 3'd4,
        S_DONE  = 3'd5
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/chart_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : chart_scheduler_if
// Brief    : Chart ROM port and spawn handshake between scheduler and lanes.
// Revision : 1.0 - initial release
// ============================================================================
interface chart_scheduler_if
    import chart_pkg::*;
#(
    parameter int TIME_W = c_time_w,
    parameter int ADDR_W = c_addr_w,
    parameter int LANES  = c_lanes
);
    logic [ADDR_W-1:0]       chart_addr;
    logic [TIME_W+LANES-1:0] chart_data;
    logic                    spawn_valid;
    logic [LANES-1:0]        spawn_lanes;
    logic [TIME_W-1:0]       spawn_time;
    logic                    spawn_ready;

    modport master (
        output chart_addr, spawn_valid, spawn_lanes, spawn_time,
        input  chart_data, spawn_ready
    );

    modport slave (
        input  chart_addr, spawn_valid, spawn_lanes, spawn_time,
        output chart_data, spawn_ready
    );
endinterface
`default_nettype wire

// File: rtl/chart_scheduler_song_timer.sv
`default_nettype none
// ============================================================================
// Module   : song_timer
// Brief    : Saturating song-frame counter with enable and synchronous clear.
// Revision : 1.0 - initial release
// ============================================================================
module song_timer
    import chart_pkg::*;
#(
    parameter int TIME_W = c_time_w
) (
    input  wire logic              Clk,
    input  wire logic              Reset_n,
    input  wire logic              i_clr,
    input  wire logic              i_en,
    output logic [TIME_W-1:0]      o_count
);
    logic [TIME_W-1:0] r_count;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && !(&r_count)) begin
            r_count <= r_count + TIME_W'(1);
        end
    end

    assign o_count = r_count;
endmodule
`default_nettype wire

// File: rtl/chart_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : chart_scheduler
// Brief    : Walks the note chart ROM and issues lane spawns LEAD frames early.
// Revision : 1.0 - initial release
// ============================================================================
module chart_scheduler
    import chart_pkg::*;
#(
    parameter int TIME_W = c_time_w,
    parameter int ADDR_W = c_addr_w,
    parameter int LANES  = c_lanes,
    parameter int LEAD   = c_lead
) (
    input  wire logic          Clk,
    input  wire logic          Reset_n,
    input  wire logic          start,
    input  wire logic          pause,
    input  wire logic          frame_tick,
    chart_scheduler_if.master  bus,
    output logic [TIME_W-1:0]  song_time,
    output logic               busy,
    output logic               done
);
    typedef struct packed {
        logic [TIME_W-1:0] hit_time;
        logic [LANES-1:0]  lane_mask;
    } entry_t;

    sched_state_t      r_state;
    sched_state_t      w_state_nxt;
    entry_t            r_entry;
    entry_t            w_rom_entry;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic              r_spawn_valid;
    logic [LANES-1:0]  r_spawn_lanes;
    logic [TIME_W-1:0] r_spawn_time;
    logic              r_busy;
    logic              r_done;
    logic [TIME_W:0]   w_limit;
    logic              w_due;
    logic              w_accept;
    logic              w_time_en;

    assign w_rom_entry = bus.chart_data;

    // One extra bit keeps song_time + LEAD from wrapping near the end of time
    assign w_limit  = {1'b0, song_time} + (TIME_W+1)'(LEAD);
    assign w_due    = ({1'b0, r_entry.hit_time} <= w_limit);
    assign w_accept = r_spawn_valid && bus.spawn_ready;

    assign w_time_en = frame_tick && !pause && (r_state != S_IDLE);

    song_timer #(
        .TIME_W (TIME_W)
    ) u_song_timer (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .i_clr   (start),
        .i_en    (w_time_en),
        .o_count (song_time)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        if (start) begin
            w_state_nxt = S_FETCH;
            w_addr_nxt  = '0;
        end else begin
            case (r_state)
                S_FETCH: w_state_nxt = S_WAIT;
                S_WAIT:  w_state_nxt = (w_rom_entry.lane_mask == '0) ? S_DONE : S_HOLD;
                S_HOLD:  if (w_due) w_state_nxt = S_ISSUE;
                S_ISSUE: begin
                    if (w_accept) begin
                        if (&r_addr) begin
                            w_state_nxt = S_DONE;
                        end else begin
                            w_state_nxt = S_FETCH;
                            w_addr_nxt  = r_addr + ADDR_W'(1);
                        end
                    end
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // Outputs are registered from the next state so they change with it
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_addr        <= '0;
            r_entry       <= '0;
            r_spawn_valid <= 1'b0;
            r_spawn_lanes <= '0;
            r_spawn_time  <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_addr        <= w_addr_nxt;
            r_spawn_valid <= (w_state_nxt == S_ISSUE);
            r_busy        <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
            r_done        <= (w_state_nxt == S_DONE);
            if (r_state == S_WAIT) begin
                r_entry <= w_rom_entry;
            end
            if ((r_state == S_HOLD) && (w_state_nxt == S_ISSUE)) begin
                r_spawn_lanes <= r_entry.lane_mask;
                r_spawn_time  <= r_entry.hit_time;
            end
        end
    end

    assign bus.chart_addr  = r_addr;
    assign bus.spawn_valid = r_spawn_valid;
    assign bus.spawn_lanes = r_spawn_lanes;
    assign bus.spawn_time  = r_spawn_time;
    assign busy            = r_busy;
    assign done            = r_done;
endmodule
`default_nettype wire
